// File: rtl/qbert_pkg.sv
// qbert_pkg: shared types and register bit positions for the jump command path
package qbert_pkg;
  typedef enum logic [1:0] {UR, UL, DR, DL} jump_dir_t;
  typedef enum logic [1:0] {PRIME, IDLE, COOLDOWN} state_t;
  localparam int JUMP_SEQ = 7;
  localparam int JUMP_CMD = 2;
  localparam int JUMP_DIR = 0;
  localparam int STATUS_EN = 1;
  localparam int STATUS_FLUSH = 0;
  localparam int TOPIC_OVF = 7;
  localparam int TOPIC_CNT = 4;
  localparam int TOPIC_VALID = 3;
  localparam int TOPIC_DROP = 0;
endpackage

// File: rtl/jump_fifo.sv
// jump_fifo: registered FIFO with valid/ready head, flush wins over push and pop
module jump_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 2,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] data_in,
  input  logic             ready,
  input  logic             flush,
  output logic             valid,
  output logic [WIDTH-1:0] data_out,
  output logic [CW-1:0]    count,
  output logic             full
);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wr, rd;
  logic pop, wr_en;
  assign valid = count != '0;
  assign full = count == CW'(DEPTH);
  assign data_out = mem[rd];
  assign pop = valid & ready & ~flush;
  // a full FIFO still accepts when the head leaves in the same cycle
  assign wr_en = push & ~flush & (~full | pop);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr <= '0;
      rd <= '0;
      count <= '0;
    end else if (flush) begin
      wr <= '0;
      rd <= '0;
      count <= '0;
    end else begin
      if (wr_en) mem[wr] <= data_in;
      wr <= wr + AW'(wr_en);
      rd <= rd + AW'(pop);
      count <= count + CW'(wr_en) - CW'(pop);
    end
endmodule

// File: rtl/jump_cmd_queue.sv
// jump_cmd_queue: detects toggled jump commands from the SPI registers, rate-limits
// them with a cooldown, and queues directions for the game logic.
module jump_cmd_queue
  import qbert_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int COOLDOWN_CYC = 16
) (
  input  logic       theClock,
  input  logic       theReset,
  input  logic [7:0] Data_Jump,
  input  logic [7:0] Data_Status,
  output logic       jump_valid,
  output logic [1:0] jump_dir,
  input  logic       jump_ready,
  output logic [7:0] Data_ToPic
);
  localparam logic [7:0] CD_INIT = 8'(COOLDOWN_CYC - 1);
  state_t state, state_nx;
  jump_dir_t push_dir;
  logic last_seq, flush_q, overflow, detect, flush, pop, take, push, drop, full, unused_bits;
  logic [7:0] cd, topic_nx;
  logic [2:0] drops, count;
  assign unused_bits = ^{Data_Jump[6:3], Data_Status[7:2]};
  assign push_dir = jump_dir_t'(Data_Jump[JUMP_DIR+:2]);
  assign detect = Data_Status[STATUS_EN] & Data_Jump[JUMP_CMD] & (Data_Jump[JUMP_SEQ] != last_seq);
  assign flush = Data_Status[STATUS_FLUSH] & ~flush_q;
  assign pop = jump_valid & jump_ready;
  always_ff @(posedge theClock or negedge theReset)
    if (!theReset) state <= PRIME;
    else state <= state_nx;
  always_comb
    state_nx = ((!flush && state == IDLE && detect) || (!flush && state == COOLDOWN && cd != '0)) ? COOLDOWN : IDLE;
  always_comb begin
    take = !flush && state == IDLE && detect;
    push = take && (!full || pop);
    drop = take && full && !pop;
  end
  always_comb begin
    topic_nx = '0;
    topic_nx[TOPIC_OVF] = overflow;
    topic_nx[TOPIC_CNT+:3] = count;
    topic_nx[TOPIC_VALID] = jump_valid;
    topic_nx[TOPIC_DROP+:3] = drops;
  end
  always_ff @(posedge theClock or negedge theReset)
    if (!theReset) begin
      last_seq <= 1'b0;
      flush_q <= 1'b0;
      cd <= '0;
      overflow <= 1'b0;
      drops <= '0;
      Data_ToPic <= '0;
    end else begin
      last_seq <= Data_Jump[JUMP_SEQ];
      flush_q <= Data_Status[STATUS_FLUSH];
      cd <= take ? CD_INIT : (state == COOLDOWN && cd != '0) ? cd - 8'd1 : '0;
      overflow <= flush ? 1'b0 : overflow | drop;
      drops <= flush ? '0 : (drop && drops != 3'd7) ? drops + 3'd1 : drops;
      Data_ToPic <= topic_nx;
    end
  jump_fifo #(.DEPTH(DEPTH), .WIDTH(2)) u_fifo (
    .clk(theClock),
    .rst_n(theReset),
    .push(push),
    .data_in(push_dir),
    .ready(jump_ready),
    .flush(flush),
    .valid(jump_valid),
    .data_out(jump_dir),
    .count(count),
    .full(full)
  );
endmodule

// File: tb/tb_jump_cmd_queue.sv
// tb_jump_cmd_queue: table-driven and scoreboard checks of the jump command queue
module tb_jump_cmd_queue;
  logic theClock = 0, theReset = 0, jump_ready = 0, jump_valid;
  logic [7:0] Data_Jump = 8'h86, Data_Status = 8'h02, Data_ToPic;
  logic [1:0] jump_dir;
  int total = 0, bad = 0;
  logic seq = 1'b1;
  logic [1:0] exp_q[$];
  typedef struct {logic [1:0] dir; logic [7:0] topic;} vec_t;
  vec_t tbl[4];

  jump_cmd_queue dut (
    .theClock(theClock), .theReset(theReset), .Data_Jump(Data_Jump), .Data_Status(Data_Status),
    .jump_valid(jump_valid), .jump_dir(jump_dir), .jump_ready(jump_ready), .Data_ToPic(Data_ToPic)
  );

  always #5 theClock = ~theClock;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // scoreboard compare on every handshake, then advance one cycle
  task automatic cyc();
    if (jump_valid && jump_ready) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL pop_extra: got dir %0d want none", jump_dir);
      end else check("pop_order", {6'b0, jump_dir}, {6'b0, exp_q.pop_front()});
    end
    @(posedge theClock);
    @(negedge theClock);
  endtask

  task automatic send(input logic [1:0] d, input bit accept);
    seq = ~seq;
    Data_Jump = {seq, 4'b0, 1'b1, d};
    if (accept && (exp_q.size() < 4 || (jump_valid && jump_ready))) exp_q.push_back(d);
  endtask

  task automatic drain();
    jump_ready = 1;
    for (int i = 0; i < 8 && exp_q.size() != 0; i++) cyc();
    jump_ready = 0;
    check("drain_left", 8'(exp_q.size()), 8'd0);
    check("drain_valid", {7'b0, jump_valid}, 8'd0);
  endtask

  initial begin
    tbl[0] = '{2'd0, 8'h28};
    tbl[1] = '{2'd1, 8'h38};
    tbl[2] = '{2'd3, 8'h48};
    tbl[3] = '{2'd2, 8'hC9};
    repeat (3) cyc();
    check("rst_valid", {7'b0, jump_valid}, 8'd0);
    check("rst_dir", {6'b0, jump_dir}, 8'd0);
    check("rst_topic", Data_ToPic, 8'h00);
    theReset = 1;
    cyc();
    check("prime_no_push", {7'b0, jump_valid}, 8'd0);
    send(2'd2, 1);
    cyc();
    check("first_valid", {7'b0, jump_valid}, 8'd1);
    check("first_dir", {6'b0, jump_dir}, 8'd2);
    repeat (4) cyc();
    send(2'd1, 0);
    repeat (15) cyc();
    check("cooldown_topic", Data_ToPic, 8'h18);
    foreach (tbl[i]) begin
      send(tbl[i].dir, 1);
      repeat (20) cyc();
      check($sformatf("tbl%0d_topic", i), Data_ToPic, tbl[i].topic);
    end
    jump_ready = 1;
    send(2'd1, 1);
    cyc();
    jump_ready = 0;
    cyc();
    check("full_pp_topic", Data_ToPic, 8'hC9);
    check("full_pp_head", {6'b0, jump_dir}, 8'd0);
    drain();
    repeat (20) cyc();
    send(2'd3, 1);
    repeat (20) cyc();
    Data_Status = 8'h03;
    send(2'd0, 0);
    exp_q.delete();
    cyc();
    check("flush_empty", {7'b0, jump_valid}, 8'd0);
    check("flush_topic_lag", Data_ToPic, 8'h99);
    cyc();
    check("flush_topic", Data_ToPic, 8'h00);
    send(2'd2, 1);
    cyc();
    check("post_flush_valid", {7'b0, jump_valid}, 8'd1);
    check("post_flush_dir", {6'b0, jump_dir}, 8'd2);
    repeat (3) cyc();
    check("hold_dir", {6'b0, jump_dir}, 8'd2);
    Data_Status = 8'h02;
    repeat (16) cyc();
    send(2'd1, 1);
    repeat (20) cyc();
    send(2'd3, 1);
    repeat (4) cyc();
    check("three_topic", Data_ToPic, 8'h38);
    theReset = 0;
    #1;
    check("rst_cd_valid", {7'b0, jump_valid}, 8'd0);
    check("rst_cd_dir", {6'b0, jump_dir}, 8'd0);
    check("rst_cd_topic", Data_ToPic, 8'h00);
    exp_q.delete();
    cyc();
    theReset = 1;
    repeat (3) cyc();
    check("no_replay", {7'b0, jump_valid}, 8'd0);
    Data_Status = 8'h00;
    send(2'd0, 0);
    repeat (2) cyc();
    check("disabled_drop", {7'b0, jump_valid}, 8'd0);
    Data_Status = 8'h02;
    send(2'd3, 1);
    cyc();
    check("reenable_valid", {7'b0, jump_valid}, 8'd1);
    check("reenable_dir", {6'b0, jump_dir}, 8'd3);
    drain();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
